// File: rtl/community_job_sched_if.sv
// Handshake bundle between the job scheduler, its requesters, the result consumer and the
// community-assignment engine. The scheduler connects through the slave modport.
interface community_job_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int PRECISION = 16
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   gnt;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2:0]           rsp_id;
  logic [PRECISION-1:0] rsp_modularity;
  logic                 rsp_err;
  logic                 eng_start;
  logic                 eng_done;
  logic [PRECISION-1:0] eng_modularity;
  logic                 busy;
  logic [15:0]          jobs_done;
  logic [7:0]           timeouts;

  modport master (
    output req, rsp_ready, eng_done, eng_modularity,
    input  gnt, rsp_valid, rsp_id, rsp_modularity, rsp_err, eng_start,
           busy, jobs_done, timeouts
  );

  modport slave (
    input  req, rsp_ready, eng_done, eng_modularity,
    output gnt, rsp_valid, rsp_id, rsp_modularity, rsp_err, eng_start,
           busy, jobs_done, timeouts
  );
endinterface

// File: rtl/community_job_sched.sv
// Round-robin scheduler that hands one shared community-assignment engine to NUM_REQ
// requesters, one job at a time, with a run-length watchdog and job/timeout counters.
module community_job_sched #(
  parameter int NUM_REQ        = 4,
  parameter int PRECISION      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   rst,
  community_job_sched_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_RESP, S_RELEASE
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [2:0]           owner_q, owner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 arm_q, arm_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2:0]           rsp_id_q, rsp_id_d;
  logic [PRECISION-1:0] mod_q, mod_d;
  logic                 err_q, err_d;
  logic                 eng_start_q, eng_start_d;
  logic [15:0]          jobs_q, jobs_d;
  logic [7:0]           to_q, to_d;
  logic [2:0]           sel;
  logic                 found;

  // Lowest set request overall, overridden by the lowest one at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (3'(i) >= rr_ptr_q)) sel = 3'(i);
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    gnt_d     = '0;
    timer_d   = timer_q;
    arm_d     = arm_q;
    rsp_id_d  = rsp_id_q;
    mod_d     = mod_q;
    err_d     = err_q;
    jobs_d    = jobs_q;
    to_d      = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d  = sel;
          gnt_d    = NUM_REQ'(1) << sel;
          rr_ptr_d = (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
          state_d  = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        arm_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (!bus.eng_done) arm_d = 1'b1;
        // Completion is checked first so it wins over a coincident timeout.
        if (arm_q && bus.eng_done) begin
          mod_d    = bus.eng_modularity;
          err_d    = 1'b0;
          rsp_id_d = owner_q;
          state_d  = S_RESP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          mod_d    = '0;
          err_d    = 1'b1;
          rsp_id_d = owner_q;
          to_d     = (to_q == 8'hFF) ? to_q : to_q + 8'd1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          if (!err_q) jobs_d = jobs_q + 16'd1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    eng_start_d = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_RESP);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      gnt_q       <= '0;
      timer_q     <= '0;
      arm_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      mod_q       <= '0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
      jobs_q      <= '0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      timer_q     <= timer_d;
      arm_q       <= arm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      mod_q       <= mod_d;
      err_q       <= err_d;
      eng_start_q <= eng_start_d;
      jobs_q      <= jobs_d;
      to_q        <= to_d;
    end
  end

  assign bus.gnt            = gnt_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_modularity = mod_q;
  assign bus.rsp_err        = err_q;
  assign bus.eng_start      = eng_start_q;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.jobs_done      = jobs_q;
  assign bus.timeouts       = to_q;
endmodule

// File: tb/tb_community_job_sched.sv
// Directed bench: dut_a uses the default watchdog, dut_b a 16-cycle watchdog; both see the
// same requester, consumer and engine stimulus.
module tb_community_job_sched;
  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        rsp_ready;
  logic        eng_done;
  logic [15:0] eng_modularity;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  community_job_sched_if #(.NUM_REQ(4), .PRECISION(16)) ifa ();
  community_job_sched_if #(.NUM_REQ(4), .PRECISION(16)) ifb ();

  assign ifa.req            = req;
  assign ifa.rsp_ready      = rsp_ready;
  assign ifa.eng_done       = eng_done;
  assign ifa.eng_modularity = eng_modularity;
  assign ifb.req            = req;
  assign ifb.rsp_ready      = rsp_ready;
  assign ifb.eng_done       = eng_done;
  assign ifb.eng_modularity = eng_modularity;

  community_job_sched #(.NUM_REQ(4), .PRECISION(16), .TIMEOUT_CYCLES(65535)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  community_job_sched #(.NUM_REQ(4), .PRECISION(16), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are read 1 time unit after the rising edge, inputs change at the same point.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b0000; rsp_ready = 1'b0; eng_done = 1'b0; eng_modularity = 16'h0;
    apply_reset();
    total++; if (ifa.gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %0h want 0", ifa.gnt); end
    total++; if (ifa.rsp_valid !== 1'b0 || ifa.eng_start !== 1'b0 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: valid=%0b start=%0b busy=%0b want all 0", ifa.rsp_valid, ifa.eng_start, ifa.busy);
    end
    total++; if (ifa.rsp_id !== 3'd0 || ifa.rsp_modularity !== 16'h0 || ifa.rsp_err !== 1'b0) begin
      bad++; $display("FAIL reset_rsp: id=%0d mod=%0h err=%0b want 0", ifa.rsp_id, ifa.rsp_modularity, ifa.rsp_err);
    end
    total++; if (ifa.jobs_done !== 16'd0 || ifa.timeouts !== 8'd0) begin
      bad++; $display("FAIL reset_cnt: jobs=%0d to=%0d want 0", ifa.jobs_done, ifa.timeouts);
    end
    step(1);
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL idle_no_req: busy=%0b want 0", ifa.busy); end
  endtask

  task automatic test_basic_job();
    req = 4'b0010;
    step(1);
    total++; if (ifa.gnt !== 4'b0010) begin bad++; $display("FAIL basic_gnt: got %0b want 0010", ifa.gnt); end
    total++; if (ifa.eng_start !== 1'b1 || ifa.busy !== 1'b1) begin
      bad++; $display("FAIL basic_start: start=%0b busy=%0b want 1 1", ifa.eng_start, ifa.busy);
    end
    req = 4'b0000;
    step(1);
    total++; if (ifa.gnt !== 4'b0000) begin bad++; $display("FAIL basic_gnt_pulse: got %0b want 0000", ifa.gnt); end
    step(18);
    total++; if (ifa.rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %0b want 0", ifa.rsp_valid); end
    eng_done = 1'b1; eng_modularity = 16'h00C0;
    step(1);
    total++; if (ifa.rsp_valid !== 1'b1 || ifa.rsp_id !== 3'd1 || ifa.rsp_modularity !== 16'h00C0 || ifa.rsp_err !== 1'b0) begin
      bad++; $display("FAIL basic_rsp: valid=%0b id=%0d mod=%0h err=%0b want 1 1 c0 0",
                      ifa.rsp_valid, ifa.rsp_id, ifa.rsp_modularity, ifa.rsp_err);
    end
    rsp_ready = 1'b1;
    step(1);
    total++; if (ifa.eng_start !== 1'b0 || ifa.rsp_valid !== 1'b0 || ifa.jobs_done !== 16'd1) begin
      bad++; $display("FAIL basic_accept: start=%0b valid=%0b jobs=%0d want 0 0 1", ifa.eng_start, ifa.rsp_valid, ifa.jobs_done);
    end
    rsp_ready = 1'b0; eng_done = 1'b0;
    step(1);
    total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL basic_idle: busy=%0b want 0", ifa.busy); end
  endtask

  task automatic test_resp_stall();
    // rr_ptr is 2 after the previous job, so the lone request 0 is reached by wrapping.
    req = 4'b0001;
    step(1);
    total++; if (ifa.gnt !== 4'b0001) begin bad++; $display("FAIL stall_gnt: got %0b want 0001", ifa.gnt); end
    req = 4'b0000;
    step(2);
    eng_done = 1'b1; eng_modularity = 16'h5A5A;
    step(1);
    eng_modularity = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({ifa.rsp_valid, ifa.eng_start, ifa.rsp_err, ifa.rsp_id, ifa.rsp_modularity} !== {1'b1, 1'b1, 1'b0, 3'd0, 16'h5A5A}) begin
        bad++; $display("FAIL stall_hold[%0d]: valid=%0b start=%0b err=%0b id=%0d mod=%0h want 1 1 0 0 5a5a",
                        i, ifa.rsp_valid, ifa.eng_start, ifa.rsp_err, ifa.rsp_id, ifa.rsp_modularity);
      end
      step(1);
    end
    rsp_ready = 1'b1;
    step(1);
    total++; if (ifa.eng_start !== 1'b0 || ifa.rsp_valid !== 1'b0 || ifa.busy !== 1'b1) begin
      bad++; $display("FAIL stall_release: start=%0b valid=%0b busy=%0b want 0 0 1", ifa.eng_start, ifa.rsp_valid, ifa.busy);
    end
    rsp_ready = 1'b0; eng_done = 1'b0;
    step(1);
    total++; if (ifa.eng_start !== 1'b0 || ifa.busy !== 1'b0 || ifa.jobs_done !== 16'd2) begin
      bad++; $display("FAIL stall_idle: start=%0b busy=%0b jobs=%0d want 0 0 2", ifa.eng_start, ifa.busy, ifa.jobs_done);
    end
  endtask

  task automatic test_round_robin();
    int last;
    int c;
    logic [3:0] exp;
    apply_reset();
    req = 4'b1111; rsp_ready = 1'b1; eng_done = 1'b0;
    last = 0;
    for (int j = 0; j < 5; j++) begin
      c = 0;
      while (ifa.gnt == 4'b0 && c < 12) begin
        step(1);
        c++;
      end
      exp = 4'b0001 << (j % 4);
      total++; if (ifa.gnt !== exp) begin bad++; $display("FAIL rr_gnt[%0d]: got %0b want %0b", j, ifa.gnt, exp); end
      // Shortest job: START, two WAIT cycles (arm then done), RESP, RELEASE, IDLE.
      if (j > 0) begin
        total++; if (cyc - last !== 6) begin bad++; $display("FAIL rr_spacing[%0d]: got %0d want 6", j, cyc - last); end
      end
      last = cyc;
      step(2);
      eng_done = 1'b1;
      step(1);
      eng_done = 1'b0;
    end
    req = 4'b0000;
    step(2);
    rsp_ready = 1'b0;
    total++; if (ifa.jobs_done !== 16'd5 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL rr_jobs: jobs=%0d busy=%0b want 5 0", ifa.jobs_done, ifa.busy);
    end
  endtask

  task automatic test_done_stuck();
    apply_reset();
    eng_done = 1'b1; eng_modularity = 16'hBEEF; req = 4'b0001; rsp_ready = 1'b0;
    step(1);
    total++; if (ifb.gnt !== 4'b0001) begin bad++; $display("FAIL stuck_gnt: got %0b want 0001", ifb.gnt); end
    req = 4'b0000;
    step(16);
    total++; if (ifb.rsp_valid !== 1'b0) begin bad++; $display("FAIL stuck_early: valid=%0b want 0", ifb.rsp_valid); end
    step(1);
    total++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b1 || ifb.rsp_modularity !== 16'h0 || ifb.timeouts !== 8'd1) begin
      bad++; $display("FAIL stuck_timeout: valid=%0b err=%0b mod=%0h to=%0d want 1 1 0 1",
                      ifb.rsp_valid, ifb.rsp_err, ifb.rsp_modularity, ifb.timeouts);
    end
    rsp_ready = 1'b1;
    step(1);
    total++; if (ifb.jobs_done !== 16'd0 || ifb.eng_start !== 1'b0) begin
      bad++; $display("FAIL stuck_accept: jobs=%0d start=%0b want 0 0", ifb.jobs_done, ifb.eng_start);
    end
    rsp_ready = 1'b0; eng_done = 1'b0;
    step(1);
  endtask

  task automatic test_complete_vs_timeout();
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    step(16);
    eng_done = 1'b1; eng_modularity = 16'h1234;
    step(1);
    total++; if (ifb.rsp_valid !== 1'b1 || ifb.rsp_err !== 1'b0 || ifb.rsp_modularity !== 16'h1234 || ifb.timeouts !== 8'd1) begin
      bad++; $display("FAIL tie_completion: valid=%0b err=%0b mod=%0h to=%0d want 1 0 1234 1",
                      ifb.rsp_valid, ifb.rsp_err, ifb.rsp_modularity, ifb.timeouts);
    end
    rsp_ready = 1'b1;
    step(1);
    total++; if (ifb.jobs_done !== 16'd1) begin bad++; $display("FAIL tie_jobs: got %0d want 1", ifb.jobs_done); end
    rsp_ready = 1'b0; eng_done = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    step(2);
    eng_done = 1'b1; eng_modularity = 16'h0077;
    step(1);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0; eng_done = 1'b0;
    step(1);
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    step(3);
    eng_done = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    total++; if (ifa.gnt !== 4'b0 || ifa.eng_start !== 1'b0 || ifa.rsp_valid !== 1'b0 || ifa.busy !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl: gnt=%0b start=%0b valid=%0b busy=%0b want 0",
                      ifa.gnt, ifa.eng_start, ifa.rsp_valid, ifa.busy);
    end
    total++; if (ifa.rsp_id !== 3'd0 || ifa.rsp_modularity !== 16'h0 || ifa.jobs_done !== 16'd0) begin
      bad++; $display("FAIL midrst_data: id=%0d mod=%0h jobs=%0d want 0 0 0", ifa.rsp_id, ifa.rsp_modularity, ifa.jobs_done);
    end
    eng_done = 1'b0;
    step(3);
    total++; if (ifa.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_norsp: valid=%0b want 0", ifa.rsp_valid); end
    req = 4'b1111;
    step(1);
    total++; if (ifa.gnt !== 4'b0001) begin bad++; $display("FAIL midrst_ptr: got %0b want 0001", ifa.gnt); end
    req = 4'b0000;
    step(2);
    eng_done = 1'b1;
    step(1);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0; eng_done = 1'b0;
    step(1);
  endtask

  task automatic test_timeout_saturation();
    int c;
    logic [7:0] exp;
    apply_reset();
    eng_done = 1'b1; req = 4'b0001; rsp_ready = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      c = 0;
      while (ifb.rsp_valid !== 1'b1 && c < 40) begin
        step(1);
        c++;
      end
      if (ifb.rsp_valid !== 1'b1) begin
        total++; bad++;
        $display("FAIL sat_wait[%0d]: no response within 40 cycles", k);
        break;
      end
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
        exp = (k < 255) ? 8'(k) : 8'd255;
        total++; if (ifb.timeouts !== exp || ifb.rsp_err !== 1'b1) begin
          bad++; $display("FAIL sat_count[%0d]: to=%0d err=%0b want %0d 1", k, ifb.timeouts, ifb.rsp_err, exp);
        end
      end
      step(1);
    end
    req = 4'b0000; eng_done = 1'b0;
    step(3);
    rsp_ready = 1'b0;
    total++; if (ifb.timeouts !== 8'd255 || ifb.jobs_done !== 16'd0) begin
      bad++; $display("FAIL sat_final: to=%0d jobs=%0d want 255 0", ifb.timeouts, ifb.jobs_done);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; rsp_ready = 1'b0; eng_done = 1'b0; eng_modularity = 16'h0;
    test_reset();
    test_basic_job();
    test_resp_stall();
    test_round_robin();
    test_done_stuck();
    test_complete_vs_timeout();
    test_reset_mid();
    test_timeout_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
